// File: rtl/power_meter_if.sv
// Player-facing bundle of the power meter: controls in, display and capture out.
// The meter is the slave; the game logic (or a bench) is the master.
interface power_meter_if #(
  parameter int LEVELS = 8,
  parameter int LVL_W  = 4
);
  logic              start;
  logic              lock;
  logic              clr;
  logic [1:0]        SW;
  logic [LEVELS-1:0] LEDR;
  logic [LVL_W-1:0]  pow_lvl;
  logic              valid;
  logic              busy;

  modport master (
    output start, lock, clr, SW,
    input  LEDR, pow_lvl, valid, busy
  );

  modport slave (
    input  start, lock, clr, SW,
    output LEDR, pow_lvl, valid, busy
  );
endinterface

// File: rtl/power_meter.sv
// Swing-power meter: level sweeps 0..LEVELS..0, a lock press captures it.
// Optional: POWER_METER_BLINK_EN blinks the captured bar while LOCKED.
module power_meter #(
  parameter int LEVELS   = 8,
  parameter int LVL_W    = 4,
  parameter int TICK_DIV = 2500000
) (
  input  logic          CLOCK_50,
  input  logic          KEY,
  power_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_LOCK
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_n;
  logic [31:0]       r_cnt;
  logic [31:0]       w_cnt_n;
  logic              r_lock_q;
  logic [LVL_W-1:0]  r_pow;
  logic [LVL_W-1:0]  w_pow_n;
  logic              r_valid;
  logic              w_valid_n;
  logic [LEVELS-1:0] r_ledr;
  logic [LEVELS-1:0] w_therm;
  logic [LEVELS-1:0] w_ledr_n;
  logic [31:0]       w_period;
  logic [31:0]       w_thr;
  logic              w_tick;
  logic              w_lock_edge;

`ifdef POWER_METER_BLINK_EN
  logic              r_blink;
  logic              w_blink_n;
`endif

  assign w_period    = 32'(TICK_DIV) >> bus.SW;
  assign w_thr       = w_period - 32'd1;
  // >= rather than == so a faster SW mid-count cannot overrun
  assign w_tick      = (r_cnt >= w_thr);
  assign w_lock_edge = bus.lock & ~r_lock_q;

  always_comb begin
    w_state_n = r_state;
    w_level_n = r_level;
    w_cnt_n   = r_cnt;
    w_pow_n   = r_pow;
    w_valid_n = 1'b0;
`ifdef POWER_METER_BLINK_EN
    w_blink_n = r_blink;
`endif
    if (bus.clr) begin
      w_state_n = S_IDLE;
      w_level_n = '0;
      w_cnt_n   = '0;
`ifdef POWER_METER_BLINK_EN
      w_blink_n = 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_level_n = '0;
          w_cnt_n   = '0;
          if (bus.start)
            w_state_n = S_UP;
        end
        S_UP, S_DOWN: begin
          if (w_lock_edge) begin
            w_pow_n   = r_level;
            w_valid_n = 1'b1;
            w_state_n = S_LOCK;
            w_cnt_n   = '0;
          end else if (w_tick) begin
            w_cnt_n = '0;
            if (r_state == S_UP) begin
              w_level_n = r_level + LVL_W'(1);
              if (r_level == LVL_W'(LEVELS - 1))
                w_state_n = S_DOWN;
            end else begin
              w_level_n = r_level - LVL_W'(1);
              if (r_level == LVL_W'(1))
                w_state_n = S_UP;
            end
          end else begin
            w_cnt_n = r_cnt + 32'd1;
          end
        end
        S_LOCK: begin
`ifdef POWER_METER_BLINK_EN
          if (w_tick) begin
            w_cnt_n   = '0;
            w_blink_n = ~r_blink;
          end else begin
            w_cnt_n = r_cnt + 32'd1;
          end
`else
          w_cnt_n = '0;
`endif
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < LEVELS; i++)
      w_therm[i] = (LVL_W'(i) < r_level);
`ifdef POWER_METER_BLINK_EN
    w_ledr_n = r_blink ? '0 : w_therm;
`else
    w_ledr_n = w_therm;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_state  <= S_IDLE;
      r_level  <= '0;
      r_cnt    <= '0;
      r_lock_q <= 1'b0;
      r_pow    <= '0;
      r_valid  <= 1'b0;
      r_ledr   <= '0;
`ifdef POWER_METER_BLINK_EN
      r_blink  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_level  <= w_level_n;
      r_cnt    <= w_cnt_n;
      r_lock_q <= bus.lock;
      r_pow    <= w_pow_n;
      r_valid  <= w_valid_n;
      r_ledr   <= w_ledr_n;
`ifdef POWER_METER_BLINK_EN
      r_blink  <= w_blink_n;
`endif
    end
  end

  assign bus.LEDR    = r_ledr;
  assign bus.pow_lvl = r_pow;
  assign bus.valid   = r_valid;
  assign bus.busy    = (r_state == S_UP) || (r_state == S_DOWN);

endmodule

// File: tb/tb_power_meter.sv
// Bench for power_meter: vector table through a scoreboard queue,
// plus hand-written async-reset and blink sequences.
module tb_power_meter;

  logic clk = 1'b0;
  logic key = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  power_meter_if #(.LEVELS(8), .LVL_W(4)) pm ();

  power_meter #(
    .LEVELS  (8),
    .LVL_W   (4),
    .TICK_DIV(8)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .bus     (pm.slave)
  );

  typedef struct {
    logic       st;
    logic       lk;
    logic       cl;
    logic [1:0] sw;
    int         cyc;
    logic [7:0] ledr;
    logic [3:0] pow;
    logic       val;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

`ifdef POWER_METER_BLINK_EN
  localparam logic [7:0] L21 = 8'h00;
`else
  localparam logic [7:0] L21 = 8'h07;
`endif

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [7:0] l, logic [3:0] p,
                         logic v, logic b);
    chk({nm, ".ledr"}, 32'(pm.LEDR), 32'(l));
    chk({nm, ".pow"}, 32'(pm.pow_lvl), 32'(p));
    chk({nm, ".valid"}, 32'(pm.valid), 32'(v));
    chk({nm, ".busy"}, 32'(pm.busy), 32'(b));
  endtask

  function automatic void add(logic st, logic lk, logic cl, logic [1:0] sw,
                              int cyc, logic [7:0] ledr, logic [3:0] pow,
                              logic val, logic busy);
    vec_t v;
    v.st = st; v.lk = lk; v.cl = cl; v.sw = sw; v.cyc = cyc;
    v.ledr = ledr; v.pow = pow; v.val = val; v.busy = busy;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    //   st lk cl sw cyc  ledr  pow val busy
    add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8'h00, 0, 0, 1);
    add(0, 0, 0, 0, 9, 8'h01, 0, 0, 1);
    add(0, 0, 0, 0, 8, 8'h03, 0, 0, 1);
    add(0, 0, 0, 0, 8, 8'h07, 0, 0, 1);
    add(0, 0, 0, 0, 8, 8'h0F, 0, 0, 1);
    add(0, 0, 0, 0, 8, 8'h1F, 0, 0, 1);
    add(0, 1, 0, 0, 1, 8'h1F, 5, 1, 0);
    add(0, 1, 0, 0, 1, 8'h1F, 5, 0, 0);
    add(1, 0, 0, 0, 3, 8'h1F, 5, 0, 0);
    add(0, 1, 0, 0, 1, 8'h1F, 5, 0, 0);
    add(0, 0, 1, 0, 2, 8'h00, 5, 0, 0);
    add(1, 0, 0, 3, 1, 8'h00, 5, 0, 1);
    add(0, 0, 0, 3, 4, 8'h07, 5, 0, 1);
    add(0, 0, 0, 3, 5, 8'hFF, 5, 0, 1);
    add(0, 0, 0, 3, 1, 8'h7F, 5, 0, 1);
    add(0, 0, 0, 3, 7, 8'h00, 5, 0, 1);
    add(0, 0, 0, 3, 1, 8'h01, 5, 0, 1);
    add(0, 0, 0, 3, 1, 8'h03, 5, 0, 1);
    add(0, 1, 0, 3, 1, 8'h07, 3, 1, 0);
    add(0, 1, 0, 3, 2, L21,   3, 0, 0);
    add(0, 0, 1, 3, 2, 8'h00, 3, 0, 0);
    add(1, 0, 0, 0, 1, 8'h00, 3, 0, 1);
    add(0, 1, 1, 0, 1, 8'h00, 3, 0, 0);
    add(0, 1, 0, 0, 1, 8'h00, 3, 0, 0);
    add(1, 1, 0, 0, 1, 8'h00, 3, 0, 1);
    add(0, 1, 0, 0, 3, 8'h00, 3, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 3, 0, 1);
    add(0, 1, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 0, 1, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8'h00, 0, 0, 1);
    add(0, 0, 0, 0, 5, 8'h00, 0, 0, 1);
    add(0, 0, 0, 3, 2, 8'h01, 0, 0, 1);
    add(0, 1, 0, 3, 1, 8'h03, 2, 1, 0);
    add(0, 0, 1, 0, 2, 8'h00, 2, 0, 0);
    add(1, 0, 0, 0, 1, 8'h00, 2, 0, 1);
    add(0, 0, 0, 0, 20, 8'h03, 2, 0, 1);

    pm.start = 1'b0;
    pm.lock  = 1'b0;
    pm.clr   = 1'b0;
    pm.SW    = 2'd0;
    @(negedge clk);
    chk_all("in_reset", 8'h00, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    key = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pm.start = tbl[i].st;
      pm.lock  = tbl[i].lk;
      pm.clr   = tbl[i].cl;
      pm.SW    = tbl[i].sw;
      sb.push_back(tbl[i]);
      repeat (tbl[i].cyc) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk_all($sformatf("v%0d", i), e.ledr, e.pow, e.val, e.busy);
    end

    // asynchronous reset in the middle of a sweep, between clock edges
    #2 key = 1'b0;
    #1 chk_all("async_rst", 8'h00, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    key = 1'b1;
    repeat (10) @(negedge clk);
    chk_all("post_rst", 8'h00, 4'd0, 1'b0, 1'b0);

`ifdef POWER_METER_BLINK_EN
    pm.SW    = 2'd0;
    pm.start = 1'b1;
    @(negedge clk);
    pm.start = 1'b0;
    repeat (33) @(negedge clk);
    chk("blink.pre", 32'(pm.LEDR), 32'h0F);
    pm.lock = 1'b1;
    repeat (4) @(negedge clk);
    chk_all("blink.on", 8'h0F, 4'd4, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("blink.off", 32'(pm.LEDR), 32'h00);
    repeat (8) @(negedge clk);
    chk("blink.on2", 32'(pm.LEDR), 32'h0F);
    pm.lock = 1'b0;
    pm.clr  = 1'b1;
    repeat (2) @(negedge clk);
    pm.clr = 1'b0;
    chk("blink.clr", 32'(pm.LEDR), 32'h00);
    repeat (10) @(negedge clk);
    chk("blink.steady", 32'(pm.LEDR), 32'h00);
`endif

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/power_meter.md
# power_meter

Parametrised swing-power meter for the bowling game. On `start` a power level sweeps up and down between 0 and `LEVELS` at a switch-selectable rate. A lock press captures the current level, which is displayed as a thermometer bar on the red LEDs. The locked value is handed to the ball-launch logic through `pow_lvl`/`valid`. It replaces the fixed 3-bit, switch-driven power display with a timed, player-driven meter.

## Interface
Parameters:
- `LEVELS`, 8: number of LED segments and the maximum power level.
- `LVL_W`, 4: width of `pow_lvl`; must satisfy `LEVELS < 2**LVL_W`.
- `TICK_DIV`, 2500000: base sweep step period in clock cycles; must be ≥ 8.

Ports:
- `CLOCK_50`  in  1  system clock.
- `KEY`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  active-high, synchronous; begins a sweep from IDLE.
- `lock`  in  1  active-high level, synchronous (debounced upstream); a rising edge captures the level.
- `clr`  in  1  active-high, synchronous; returns to IDLE from any state.
- `SW`  in  2  speed select; step period is `TICK_DIV >> SW`.
- `LEDR`  out  `LEVELS`  thermometer display: `LEDR[i] = (i < level)`.
- `pow_lvl`  out  `LVL_W`  captured power level; holds its value until the next capture or reset.
- `valid`  out  1  one-cycle pulse when `pow_lvl` is updated.
- `busy`  out  1  high in SWEEP_UP and SWEEP_DOWN.

## Operation
- States: IDLE, SWEEP_UP, SWEEP_DOWN, LOCKED.
- Internal registers:
  - `level` (`LVL_W` bits).
  - prescaler counter (32 bits).
  - `lock_q`, the previous `lock`, for edge detection.
- Tick: prescaler counts while sweeping. When `count >= (TICK_DIV >> SW) - 1`, a tick asserts for one cycle and the counter clears. The `>=` compare keeps a mid-sweep `SW` change from overrunning.
- IDLE: `level` = 0 and the prescaler is held at 0. `start` → SWEEP_UP.
- SWEEP_UP: on each tick `level` increments. A tick that moves `level` to `LEVELS` also switches the state to SWEEP_DOWN.
- SWEEP_DOWN: on each tick `level` decrements. A tick that moves `level` to 0 also switches the state to SWEEP_UP. The sequence is 0,1,…,L,L-1,…,0,1,… with each endpoint shown for exactly one step period.
- Lock edge (`lock & ~lock_q`) in either sweep state:
  - `pow_lvl` ← current `level`; `valid` pulses; state → LOCKED.
  - A tick in the same cycle is discarded, so the pre-tick level is captured.
- LOCKED: `level` is frozen and `LEDR` shows it. `start` and lock edges are ignored.
- `clr`:
  - Has priority over `start`, lock and tick.
  - From any state → IDLE and `level` ← 0.
  - `pow_lvl` is retained; no `valid` pulse.
- A lock edge in IDLE or LOCKED has no effect. `lock_q` always tracks `lock`, so a lock held high during `start` does not capture until it is released and pressed again.

## Timing
- Reset (`KEY`=0), taking effect asynchronously:
  - state IDLE; `level`, prescaler and `lock_q` = 0.
  - `pow_lvl` = 0, `valid` = 0, `busy` = 0.
  - `LEDR` = all zeros.
- `start` sampled at edge N → SWEEP_UP and `busy`=1 from N+1. The first step is visible at cycle N+1+P, where P = `TICK_DIV >> SW`.
- Lock edge sampled at edge N → `valid`=1 and the new `pow_lvl` during cycle N+1 only; `busy`=0 from N+1.
- `LEDR` is a registered decode of `level` and tracks it with 1 cycle of latency.
- Reset deasserted mid-sweep: the block restarts in IDLE; no partial state survives.

## Configuration
- `POWER_METER_BLINK_EN` defined:
  - In LOCKED the prescaler keeps running, and each tick toggles a blink flag.
  - `LEDR` alternates between the thermometer pattern and all-zero, starting with the pattern on entry to LOCKED.
  - The flag clears on leaving LOCKED.
- Macro undefined: `LEDR` is steady in LOCKED and the prescaler is held at 0. `pow_lvl` and `valid` behaviour is identical in both builds.

## Test plan
All scenarios use `LEVELS`=8 and `TICK_DIV`=8.
- Reset: assert `KEY`=0 mid-sweep → `LEDR`=0, `pow_lvl`=0, `busy`=0 immediately, without waiting for a clock edge.
- Sweep with `SW`=0: `start` → `level` steps every 8 cycles through 0..8..0. `LEDR` goes 0x00, 0x01, 0x03 … 0xFF, 0x7F … 0x00. `busy`=1 throughout.
- Lock:
  - Rising edge of `lock` while `LEDR`=0x1F → `pow_lvl`=5; `valid` high for exactly 1 cycle; `busy`=0; `LEDR` stays 0x1F.
  - `start` while in LOCKED → no change.
- Speed: `SW`=3 → step every 1 cycle. Change `SW` from 0 to 3 while the prescaler is at 5 → the next tick fires on the following cycle, with no overrun.
- Simultaneous events:
  - Lock edge on a tick cycle at `level`=3 → `pow_lvl`=3.
  - `clr` and a lock edge in the same cycle → IDLE, `pow_lvl` unchanged, no `valid` pulse.
- With `POWER_METER_BLINK_EN` defined: lock at `level`=4 → `LEDR` alternates 0x0F / 0x00 every 8 cycles; `clr` → `LEDR`=0 steady.
